// File: rtl/updi_target_model.sv
// updi_target_model: UPDI target responder parsing RX FIFO frames into CS/memory accesses and TX responses
module updi_target_model #(
    parameter int          MEM_SIZE      = 256,
    parameter logic [15:0] MEM_BASE      = 16'h8000,
    parameter logic [7:0]  STATUSA_RESET = 8'h30
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        break_detected,
    input  logic                        rx_error,
    input  logic [7:0]                  rx_fifo_data_out,
    output logic                        rx_fifo_rd_en,
    input  logic                        rx_fifo_empty,
    output logic [7:0]                  tx_fifo_data_in,
    output logic                        tx_fifo_wr_en,
    input  logic                        tx_fifo_full,
    output logic                        proto_error,
    input  logic [$clog2(MEM_SIZE)-1:0] dbg_addr,
    output logic [7:0]                  dbg_data
);
    localparam int AW = $clog2(MEM_SIZE);

    typedef enum logic [3:0] {
        WAIT_SYNC, INSTR, STCS_DATA, ADDR0, ADDR1, ACK1, STS_DATA, ACK2, RESP, KEY_SKIP, ERROR
    } state_t;

    state_t      state;
    logic [7:0]  mem [MEM_SIZE];
    logic [7:0]  cs [16];
    logic [3:0]  a;
    logic [15:0] addr;
    logic        wide, is_sts, is_ldcs, primed;
    logic [3:0]  cnt;
    logic [7:0]  resp;
    logic [15:0] idx;
    logic        in_range, consuming, responding, err_in, take, give;

    // take: a byte is popped this edge; give: a response byte is pushed; the rd_en guard stops a double pop of the FWFT head
    always_comb begin
        idx        = addr - MEM_BASE;
        in_range   = ~|(idx >> AW);
        consuming  = state inside {WAIT_SYNC, INSTR, STCS_DATA, ADDR0, ADDR1, STS_DATA, KEY_SKIP, ERROR};
        responding = state inside {ACK1, ACK2, RESP};
        err_in     = rx_error && state != WAIT_SYNC;
        take       = consuming && !rx_fifo_empty && !rx_fifo_rd_en && !break_detected && !err_in;
        give       = responding && primed && !tx_fifo_full && !break_detected && !err_in;
    end

    // frame parser: break beats rx_error beats byte traffic; responses take one prime cycle before the push
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_SYNC;
            rx_fifo_rd_en   <= 1'b0;
            tx_fifo_wr_en   <= 1'b0;
            tx_fifo_data_in <= 8'h00;
            proto_error     <= 1'b0;
            primed          <= 1'b0;
            a               <= 4'd0;
            addr            <= 16'h0000;
            wide            <= 1'b0;
            is_sts          <= 1'b0;
            is_ldcs         <= 1'b0;
            cnt             <= 4'd0;
            resp            <= 8'h00;
            cs[0]           <= STATUSA_RESET;
            for (int i = 1; i < 16; i++) cs[i] <= 8'h00;
        end else begin
            rx_fifo_rd_en <= take;
            tx_fifo_wr_en <= give;
            if (break_detected) begin
                state       <= WAIT_SYNC;
                proto_error <= 1'b0;
                primed      <= 1'b0;
            end else if (err_in) begin
                state       <= ERROR;
                proto_error <= 1'b1;
                primed      <= 1'b0;
            end else if (responding && !primed) begin
                primed <= 1'b1;
                resp   <= state != RESP ? 8'h40 : is_ldcs ? cs[a] : in_range ? mem[idx[AW-1:0]] : 8'h00;
            end else if (give) begin
                tx_fifo_data_in <= resp;
                primed          <= 1'b0;
                state           <= state == ACK1 ? STS_DATA : WAIT_SYNC;
            end else if (take) begin
                case (state)
                    WAIT_SYNC: if (rx_fifo_data_out == 8'h55) state <= INSTR;
                    INSTR: begin
                        case (rx_fifo_data_out[7:5])
                            3'b100: begin
                                a       <= rx_fifo_data_out[3:0];
                                is_ldcs <= 1'b1;
                                state   <= RESP;
                            end
                            3'b110: begin
                                a     <= rx_fifo_data_out[3:0];
                                state <= STCS_DATA;
                            end
                            3'b000, 3'b010: begin
                                if (!rx_fifo_data_out[3] && rx_fifo_data_out[1:0] == 2'b00) begin
                                    wide    <= rx_fifo_data_out[2];
                                    is_sts  <= rx_fifo_data_out[6];
                                    is_ldcs <= 1'b0;
                                    state   <= ADDR0;
                                end else begin
                                    state       <= ERROR;
                                    proto_error <= 1'b1;
                                end
                            end
                            3'b111: begin
                                if (rx_fifo_data_out == 8'hE0) begin
                                    cnt   <= 4'd8;
                                    state <= KEY_SKIP;
                                end else begin
                                    state       <= ERROR;
                                    proto_error <= 1'b1;
                                end
                            end
                            default: begin
                                state       <= ERROR;
                                proto_error <= 1'b1;
                            end
                        endcase
                    end
                    STCS_DATA: begin
                        if (a != 4'd0) cs[a] <= rx_fifo_data_out;
                        state <= WAIT_SYNC;
                    end
                    ADDR0: begin
                        addr  <= {8'h00, rx_fifo_data_out};
                        state <= wide ? ADDR1 : is_sts ? ACK1 : RESP;
                    end
                    ADDR1: begin
                        addr[15:8] <= rx_fifo_data_out;
                        state      <= is_sts ? ACK1 : RESP;
                    end
                    STS_DATA: state <= ACK2;
                    KEY_SKIP: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            cs[7][4] <= 1'b1;
                            state    <= WAIT_SYNC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // data memory write from the STS data byte; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (take && state == STS_DATA && in_range) mem[idx[AW-1:0]] <= rx_fifo_data_out;
    end

    // registered backdoor read port
    always_ff @(posedge clk) begin
        if (rst) dbg_data <= 8'h00;
        else dbg_data <= mem[dbg_addr];
    end
endmodule

// File: tb/tb_updi_target_model.sv
// tb_updi_target_model: frame-level model and FIFO emulation checking updi_target_model responses
module tb_updi_target_model;
    localparam int MEM_SIZE = 256;
    localparam int MEM_BASE = 32'h8000;

    logic       clk = 1'b0, rst = 1'b1, break_detected = 1'b0, rx_error = 1'b0;
    logic       rx_fifo_empty = 1'b1, tx_fifo_full = 1'b0;
    logic [7:0] rx_fifo_data_out = 8'h00, dbg_addr = 8'h00;
    logic       rx_fifo_rd_en, tx_fifo_wr_en, proto_error;
    logic [7:0] tx_fifo_data_in, dbg_data;

    int         errors = 0, checks = 0, cyc = 0, last_pop = 0;
    bit         lat_skip = 1'b0;
    logic [7:0] rxq[$], expq[$];
    logic [7:0] mem_m [MEM_SIZE];
    logic [7:0] cs_m [16];
    logic       perr_m = 1'b0;
    logic [7:0] last_exp = 8'h00, last_got = 8'h00;

    always #5 clk = ~clk;

    updi_target_model dut (
        .clk(clk), .rst(rst), .break_detected(break_detected), .rx_error(rx_error),
        .rx_fifo_data_out(rx_fifo_data_out), .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_empty(rx_fifo_empty),
        .tx_fifo_data_in(tx_fifo_data_in), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_full(tx_fifo_full),
        .proto_error(proto_error), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic refresh();
        rx_fifo_empty    = rxq.size() == 0;
        rx_fifo_data_out = rxq.size() != 0 ? rxq[0] : 8'h00;
    endtask

    task automatic put(input logic [7:0] b);
        rxq.push_back(b);
        refresh();
    endtask

    function automatic bit in_rng(input int addr);
        return addr >= MEM_BASE && addr < MEM_BASE + MEM_SIZE;
    endfunction

    function automatic logic [7:0] rd_m(input int addr);
        return in_rng(addr) ? mem_m[addr - MEM_BASE] : 8'h00;
    endfunction

    task automatic ldcs(input logic [3:0] a);
        put(8'h55); put({4'h8, a});
        expq.push_back(cs_m[a]);
    endtask

    task automatic stcs(input logic [3:0] a, input logic [7:0] d);
        put(8'h55); put({4'hC, a}); put(d);
        if (a != 0) cs_m[a] = d;
    endtask

    task automatic lds(input int addr, input bit wide);
        put(8'h55); put(wide ? 8'h04 : 8'h00); put(addr[7:0]);
        if (wide) put(addr[15:8]);
        expq.push_back(rd_m(addr));
    endtask

    task automatic sts(input int addr, input bit wide, input logic [7:0] d);
        put(8'h55); put(wide ? 8'h44 : 8'h40); put(addr[7:0]);
        if (wide) put(addr[15:8]);
        put(d);
        expq.push_back(8'h40);
        expq.push_back(8'h40);
        if (in_rng(addr)) mem_m[addr - MEM_BASE] = d;
    endtask

    task automatic key();
        put(8'h55); put(8'hE0);
        for (int i = 0; i < 8; i++) put(8'(8'h10 + i));
        cs_m[7] = cs_m[7] | 8'h10;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rxq.size() != 0 || expq.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: rx left %0d, tx outstanding %0d", rxq.size(), expq.size());
            expq.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_break();
        @(negedge clk); break_detected = 1'b1;
        @(negedge clk); break_detected = 1'b0;
        perr_m = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rx_error();
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic dbg_chk(input logic [7:0] i, input logic [7:0] lit);
        dbg_addr = i;
        repeat (2) @(negedge clk);
        check("dbg_model", dbg_data, mem_m[i]);
        check("dbg_literal", dbg_data, lit);
    endtask

    // FIFO emulation and per-cycle response scoreboard, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            if (rx_fifo_rd_en) begin
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_on_empty: rd_en=1 with empty RX FIFO");
                end else void'(rxq.pop_front());
                last_pop = cyc;
                refresh();
            end
            if (tx_fifo_wr_en) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %02h expected no push", tx_fifo_data_in);
                end else begin
                    last_exp = expq.pop_front();
                    check("tx_data", tx_fifo_data_in, last_exp);
                    if (!lat_skip) check("tx_latency", 8'(cyc - last_pop), 8'd2);
                end
                last_got = tx_fifo_data_in;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cs_m[0] = 8'h30;
        for (int i = 1; i < 16; i++) cs_m[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 8'(rx_fifo_rd_en), 8'h00);
        check("rst_wr_en", 8'(tx_fifo_wr_en), 8'h00);
        check("rst_tx_data", tx_fifo_data_in, 8'h00);
        check("rst_proto_error", 8'(proto_error), 8'h00);
        check("rst_dbg_data", dbg_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        ldcs(4'd0); wait_idle();
        check("lit_statusa", last_got, 8'h30);
        check("proto_ok", 8'(proto_error), 8'(perr_m));

        stcs(4'd2, 8'hA5); ldcs(4'd2); wait_idle();
        check("lit_cs2", last_got, 8'hA5);
        stcs(4'd0, 8'h00); ldcs(4'd0); wait_idle();
        check("lit_statusa_ro", last_got, 8'h30);

        sts(32'h8010, 1'b1, 8'h3C); wait_idle();
        dbg_chk(8'h10, 8'h3C);
        lds(32'h8010, 1'b1); wait_idle();
        check("lit_lds", last_got, 8'h3C);

        lds(32'h0020, 1'b0); wait_idle();
        check("lit_lds_oor", last_got, 8'h00);
        sts(32'h8000, 1'b1, 8'h11); sts(32'h0000, 1'b1, 8'h77); wait_idle();
        dbg_chk(8'h00, 8'h11);
        sts(32'h80FF, 1'b1, 8'h5A); lds(32'h80FF, 1'b1); lds(32'h8100, 1'b1); wait_idle();
        dbg_chk(8'hFF, 8'h5A);
        check("lit_lds_above", last_got, 8'h00);

        pulse_rx_error();
        check("rx_error_idle", 8'(proto_error), 8'(perr_m));

        put(8'h55); put(8'h45); put(8'h55); put(8'h80); put(8'h11);
        perr_m = 1'b1;
        wait_idle();
        check("proto_set", 8'(proto_error), 8'(perr_m));
        pulse_break();
        check("proto_clear", 8'(proto_error), 8'(perr_m));
        ldcs(4'd0); wait_idle();
        check("lit_after_break", last_got, 8'h30);

        put(8'h55); wait_idle();
        pulse_rx_error();
        perr_m = 1'b1;
        put(8'h55); put(8'h80); wait_idle();
        check("rx_error_frame", 8'(proto_error), 8'(perr_m));
        pulse_break();
        check("proto_clear2", 8'(proto_error), 8'(perr_m));

        key(); wait_idle();
        tx_fifo_full = 1'b1;
        lat_skip = 1'b1;
        ldcs(4'd7);
        for (int n = 0; n < 200 && rxq.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("hold_wr_en", 8'(tx_fifo_wr_en), 8'h00);
            check("hold_data", tx_fifo_data_in, last_exp);
        end
        tx_fifo_full = 1'b0;
        wait_idle();
        lat_skip = 1'b0;
        check("lit_key_status", last_got, 8'h10);

        put(8'h55); put(8'h44); put(8'h10); wait_idle();
        pulse_break();
        ldcs(4'd0); wait_idle();
        check("lit_after_sts_break", last_got, 8'h30);
        dbg_chk(8'h10, 8'h3C);
        lds(32'h8010, 1'b1); wait_idle();
        check("lit_lds_after_break", last_got, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
